// File: rtl/root_digit_feeder.sv
// Upstream feeder for the digit-serial square-root unit: a 2-entry radicand FIFO
// followed by a shifter that emits each radicand MSB-first as 2-bit digit pairs.
module root_digit_feeder #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_hold,
  output logic [1:0]        o_x,
  output logic              o_x_valid,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy
);

  localparam int DIGITS = DATA_W / 2;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] PRELAST_CNT = CNT_W'(DIGITS - 2);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;

  state_e            state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic              first_q;
  logic              last_q;

  logic              push;
  logic              pop;

  assign o_ready = (count_q != 2'd2);
  assign push    = i_valid && o_ready;

  // The head is taken either to start from idle or to reload on the final digit,
  // so consecutive frames abut without a bubble.
  assign pop = !i_hold && (count_q != 2'd0) &&
               ((state_q == ST_IDLE) || (cnt_q == LAST_CNT));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= i_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (!i_hold) begin
      if (pop) begin
        state_q <= ST_SHIFT;
        sreg_q  <= fifo_q[rd_ptr_q];
        cnt_q   <= '0;
        valid_q <= 1'b1;
        first_q <= 1'b1;
        last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_IDLE;
              sreg_q  <= '0;
              cnt_q   <= '0;
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              sreg_q  <= {sreg_q[DATA_W-3:0], 2'b00};
              cnt_q   <= cnt_q + 1'b1;
              first_q <= 1'b0;
              last_q  <= (cnt_q == PRELAST_CNT);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_x       = sreg_q[DATA_W-1:DATA_W-2];
  assign o_x_valid = valid_q;
  assign o_first   = first_q;
  assign o_last    = last_q;
  assign o_busy    = (state_q == ST_SHIFT) || (count_q != 2'd0);

endmodule

// File: tb/tb_root_digit_feeder.sv
// Directed bench for root_digit_feeder: an 8-bit and a 16-bit instance share clock and reset.
module tb_root_digit_feeder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [7:0]  d8;
  logic        v8, h8;
  logic        rdy8, xv8, f8, l8, b8;
  logic [1:0]  x8;

  logic [15:0] d16;
  logic        v16, h16;
  logic        rdy16, xv16, f16, l16, b16;
  logic [1:0]  x16;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  root_digit_feeder #(.DATA_W(8), .CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d8), .i_valid(v8), .o_ready(rdy8),
    .i_hold(h8), .o_x(x8), .o_x_valid(xv8), .o_first(f8), .o_last(l8), .o_busy(b8)
  );

  root_digit_feeder #(.DATA_W(16), .CNT_W(8)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(d16), .i_valid(v16), .o_ready(rdy16),
    .i_hold(h16), .o_x(x16), .o_x_valid(xv16), .o_first(f16), .o_last(l16), .o_busy(b16)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_digit8(input string tag, input logic [1:0] ex, input logic ef, input logic el);
    chk({tag, ".xv"},    16'(xv8), 16'd1);
    chk({tag, ".x"},     16'(x8),  16'(ex));
    chk({tag, ".first"}, 16'(f8),  16'(ef));
    chk({tag, ".last"},  16'(l8),  16'(el));
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, ".xv"},   16'(xv8), 16'd0);
    chk({tag, ".busy"}, 16'(b8),  16'd0);
    chk({tag, ".rdy"},  16'(rdy8), 16'd1);
  endtask

  initial begin
    logic [1:0] seq [8];
    rst_n = 1'b0;
    d8 = '0; v8 = 1'b0; h8 = 1'b0;
    d16 = '0; v16 = 1'b0; h16 = 1'b0;
    #12;

    // Reset values on both instances
    chk("rst.x",     16'(x8),    16'd0);
    chk("rst.xv",    16'(xv8),   16'd0);
    chk("rst.first", 16'(f8),    16'd0);
    chk("rst.last",  16'(l8),    16'd0);
    chk("rst.busy",  16'(b8),    16'd0);
    chk("rst.rdy",   16'(rdy8),  16'd1);
    chk("rst16.xv",  16'(xv16),  16'd0);
    chk("rst16.rdy", 16'(rdy16), 16'd1);
    rst_n = 1'b1;
    tick();

    // Single frame 8'hB4 -> 2,3,1,0
    d8 = 8'hB4; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("t1.accept.xv",   16'(xv8), 16'd0);
    chk("t1.accept.busy", 16'(b8),  16'd1);
    tick(); chk_digit8("t1.d0", 2'd2, 1'b1, 1'b0);
    tick(); chk_digit8("t1.d1", 2'd3, 1'b0, 1'b0);
    tick(); chk_digit8("t1.d2", 2'd1, 1'b0, 1'b0);
    chk("t1.d2.busy", 16'(b8), 16'd1);
    tick(); chk_digit8("t1.d3", 2'd0, 1'b0, 1'b1);
    tick(); chk_idle8("t1.end");
    tick();

    // Back-to-back B4 then 1E -> 2,3,1,0,0,1,3,2 with no gap
    seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd0;
    seq[4] = 2'd0; seq[5] = 2'd1; seq[6] = 2'd3; seq[7] = 2'd2;
    d8 = 8'hB4; v8 = 1'b1;
    tick();
    d8 = 8'h1E;
    tick();
    v8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_digit8($sformatf("t2.d%0d", i), seq[i], (i % 4) == 0, (i % 4) == 3);
      tick();
    end
    chk_idle8("t2.end");
    tick();

    // Held from the start: fill FIFO, third push refused
    h8 = 1'b1;
    d8 = 8'h11; v8 = 1'b1;
    tick();
    chk("t3.after1.rdy", 16'(rdy8), 16'd1);
    d8 = 8'h22;
    tick();
    chk("t3.after2.rdy", 16'(rdy8), 16'd0);
    d8 = 8'h33;
    tick();
    v8 = 1'b0;
    chk("t3.full.rdy",  16'(rdy8), 16'd0);
    chk("t3.held.xv",   16'(xv8),  16'd0);
    chk("t3.held.busy", 16'(b8),   16'd1);
    tick();
    chk("t3.held2.xv",  16'(xv8),  16'd0);
    h8 = 1'b0;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd0; seq[3] = 2'd1;
    seq[4] = 2'd0; seq[5] = 2'd2; seq[6] = 2'd0; seq[7] = 2'd2;
    tick();
    chk("t3.pop1.rdy", 16'(rdy8), 16'd1);
    for (int i = 0; i < 8; i++) begin
      chk_digit8($sformatf("t3.d%0d", i), seq[i], (i % 4) == 0, (i % 4) == 3);
      tick();
    end
    chk_idle8("t3.end");
    tick();

    // Mid-frame hold for three edges on digit 1 of B4
    d8 = 8'hB4; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick(); chk_digit8("t4.d0", 2'd2, 1'b1, 1'b0);
    tick(); chk_digit8("t4.d1", 2'd3, 1'b0, 1'b0);
    h8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_digit8($sformatf("t4.hold%0d", i), 2'd3, 1'b0, 1'b0);
    end
    h8 = 1'b0;
    tick(); chk_digit8("t4.d2", 2'd1, 1'b0, 1'b0);
    tick(); chk_digit8("t4.d3", 2'd0, 1'b0, 1'b1);
    tick(); chk_idle8("t4.end");
    tick();

    // Async reset during digit 2 with 1E queued
    d8 = 8'hB4; v8 = 1'b1;
    tick();
    d8 = 8'h1E;
    tick();
    v8 = 1'b0;
    chk_digit8("t5.d0", 2'd2, 1'b1, 1'b0);
    tick();
    tick(); chk_digit8("t5.d2", 2'd1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.rst.x",     16'(x8),   16'd0);
    chk("t5.rst.xv",    16'(xv8),  16'd0);
    chk("t5.rst.first", 16'(f8),   16'd0);
    chk("t5.rst.last",  16'(l8),   16'd0);
    chk("t5.rst.busy",  16'(b8),   16'd0);
    chk("t5.rst.rdy",   16'(rdy8), 16'd1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_idle8($sformatf("t5.quiet%0d", i));
    end
    d8 = 8'h1E; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick(); chk_digit8("t5.new.d0", 2'd0, 1'b1, 1'b0);
    tick(); chk_digit8("t5.new.d1", 2'd1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_idle8("t5.new.end");

    // 16-bit instance: FFFF then 0000 back to back
    d16 = 16'hFFFF; v16 = 1'b1;
    tick();
    d16 = 16'h0000;
    tick();
    v16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t6.d%0d.xv", i),    16'(xv16), 16'd1);
      chk($sformatf("t6.d%0d.x", i),     16'(x16),  (i < 8) ? 16'd3 : 16'd0);
      chk($sformatf("t6.d%0d.first", i), 16'(f16),  16'((i % 8) == 0));
      chk($sformatf("t6.d%0d.last", i),  16'(l16),  16'((i % 8) == 7));
      tick();
    end
    chk("t6.end.xv",   16'(xv16), 16'd0);
    chk("t6.end.busy", 16'(b16),  16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
